// File: rtl/led_chaser_gen_if.sv
// -----------------------------------------------------------------------------
// led_chaser_gen_if
// Control and LED drive signals of the LED chaser.
//   master : drives iMODE/iSPEED/iPAUSE/iLOAD, observes oLED/oTICK/oDIR
//   slave  : the chaser itself
// Signals:
//   iMODE  [1:0]        00 bounce, 01 rotate left, 10 rotate right, 11 hold
//   iSPEED [SPD_W-1:0]  step rate select, 0 = slowest
//   iPAUSE              freeze prescaler and pattern
//   iLOAD               synchronous return to start position
//   oLED   [N_LED-1:0]  LED drive, 1 = lit
//   oTICK               one-cycle pulse per step
//   oDIR               bounce direction, 0 = toward MSB
// -----------------------------------------------------------------------------
interface led_chaser_gen_if #(
    parameter int N_LED = 10,
    parameter int SPD_W = 3
);
    logic [1:0]       iMODE;
    logic [SPD_W-1:0] iSPEED;
    logic             iPAUSE;
    logic             iLOAD;
    logic [N_LED-1:0] oLED;
    logic             oTICK;
    logic             oDIR;

    modport master (
        output iMODE, iSPEED, iPAUSE, iLOAD,
        input  oLED, oTICK, oDIR
    );

    modport slave (
        input  iMODE, iSPEED, iPAUSE, iLOAD,
        output oLED, oTICK, oDIR
    );
endinterface

// File: rtl/led_chaser_gen.sv
// -----------------------------------------------------------------------------
// led_chaser_gen
// Moves a lit window of WIN adjacent LEDs across N_LED outputs. A prescaler
// produces one step decision every 2^(DIV_W-s) cycles (s = clamped iSPEED);
// each step moves the window according to iMODE. All outputs are registered.
// Ports:
//   iCLK    system clock
//   iRST_n  asynchronous active-low reset
//   bus     led_chaser_gen_if.slave (mode/speed/pause/load in, LED/tick/dir out)
// -----------------------------------------------------------------------------
module led_chaser_gen #(
    parameter int N_LED = 10,
    parameter int WIN   = 3,
    parameter int DIV_W = 21,
    parameter int SPD_W = 3
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    led_chaser_gen_if.slave   bus
);
    localparam int                   PW       = $clog2(N_LED) + 1;
    localparam logic [PW-1:0]        PMAX     = PW'(N_LED - WIN);
    localparam logic [PW-1:0]        PLAST    = PW'(N_LED - 1);
    localparam int unsigned          SMAX     = DIV_W - 1;
    localparam logic [N_LED-1:0]     LED_INIT = {{(N_LED-WIN){1'b0}}, {WIN{1'b1}}};

    logic [DIV_W-1:0] r_cnt;
    logic [PW-1:0]    r_pos;
    logic             r_dir;
    logic             r_tick;
    logic [N_LED-1:0] r_led;

    int unsigned      w_shift;
    logic [DIV_W-1:0] w_term;
    logic             w_step;
    logic [PW-1:0]    w_pos_nxt;
    logic             w_dir_nxt;

    // Bit i lit when its distance above pos (mod N_LED) is inside the window.
    function automatic logic [N_LED-1:0] f_window(input logic [PW-1:0] p);
        logic [N_LED-1:0] f;
        logic [PW-1:0]    d;
        f = '0;
        for (int i = 0; i < N_LED; i++) begin
            d = PW'(i) + PW'(N_LED) - p;
            if (d >= PW'(N_LED))
                d = d - PW'(N_LED);
            f[i] = (d < PW'(WIN));
        end
        return f;
    endfunction

    // Terminal count 2^(DIV_W-s)-1 is simply all-ones shifted right by s.
    always_comb begin
        w_shift = (32'(bus.iSPEED) > SMAX) ? SMAX : 32'(bus.iSPEED);
        w_term  = {DIV_W{1'b1}} >> w_shift;
        w_step  = !bus.iPAUSE && (r_cnt >= w_term);
    end

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        case (bus.iMODE)
            2'b00: begin
                if (r_pos > PMAX) begin
                    w_pos_nxt = PMAX;
                end else if (!r_dir) begin
                    // Already at the top while heading up: turn around.
                    if (r_pos == PMAX) begin
                        w_pos_nxt = PMAX - PW'(1);
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos + PW'(1);
                    end
                end else begin
                    // Already at the bottom while heading down: turn around.
                    if (r_pos == '0) begin
                        w_pos_nxt = PW'(1);
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_pos_nxt = r_pos - PW'(1);
                    end
                end
                if (w_pos_nxt == PMAX)
                    w_dir_nxt = 1'b1;
                else if (w_pos_nxt == '0)
                    w_dir_nxt = 1'b0;
            end
            2'b01:   w_pos_nxt = (r_pos == PLAST) ? '0 : r_pos + PW'(1);
            2'b10:   w_pos_nxt = (r_pos == '0) ? PLAST : r_pos - PW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_cnt  <= '0;
            r_pos  <= '0;
            r_dir  <= 1'b0;
            r_tick <= 1'b0;
            r_led  <= LED_INIT;
        end else if (bus.iLOAD) begin
            r_cnt  <= '0;
            r_pos  <= '0;
            r_dir  <= 1'b0;
            r_tick <= 1'b0;
            r_led  <= LED_INIT;
        end else if (bus.iPAUSE) begin
            r_tick <= 1'b0;
        end else if (w_step) begin
            r_cnt  <= '0;
            r_pos  <= w_pos_nxt;
            r_dir  <= w_dir_nxt;
            r_tick <= 1'b1;
            r_led  <= f_window(w_pos_nxt);
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign bus.oLED  = r_led;
    assign bus.oTICK = r_tick;
    assign bus.oDIR  = r_dir;
endmodule
